jt6295_encoder: RTL and testbench



---
 rtl/jt6295_pkg.sv | 35 +++
 rtl/jt6295_enc_update.sv | 49 ++++
 rtl/jt6295_encoder.sv | 177 +++++++++++++++++
 tb/tb_jt6295_encoder.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jt6295_pkg.sv
// Shared constants for the jt6295 ADPCM encode/decode path: step table, index deltas, clamps.
package jt6295_pkg;

    localparam int IDX_MAX = 48;
    localparam logic signed [11:0] PRED_MIN = 12'sh800;
    localparam logic signed [11:0] PRED_MAX = 12'sh7FF;

    localparam logic [10:0] STEP_TAB [0:48] = '{
        11'd16,   11'd17,   11'd19,   11'd21,   11'd23,   11'd25,   11'd28,
        11'd31,   11'd34,   11'd37,   11'd41,   11'd45,   11'd50,   11'd55,
        11'd60,   11'd66,   11'd73,   11'd80,   11'd88,   11'd97,   11'd107,
        11'd118,  11'd130,  11'd143,  11'd157,  11'd173,  11'd190,  11'd209,
        11'd230,  11'd253,  11'd279,  11'd307,  11'd337,  11'd371,  11'd408,
        11'd449,  11'd494,  11'd544,  11'd598,  11'd658,  11'd724,  11'd796,
        11'd876,  11'd963,  11'd1060, 11'd1166, 11'd1282, 11'd1411, 11'd1552
    };

    localparam logic signed [4:0] IDX_DELTA [0:7] = '{
        -5'sd1, -5'sd1, -5'sd1, -5'sd1, 5'sd2, 5'sd4, 5'sd6, 5'sd8
    };

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DIFF,
        ST_Q2,
        ST_Q1,
        ST_Q0,
        ST_UPD
    } enc_state_e;

    function automatic logic [10:0] step_of(input logic [5:0] idx);
        return STEP_TAB[idx];
    endfunction

endpackage

// File: rtl/jt6295_enc_update.sv
// Combinational ADPCM predictor/step-index update, bit-identical to the jt6295 decoder.
module jt6295_enc_update
    import jt6295_pkg::*;
(
    input  logic        [3:0]  code_i,
    input  logic signed [11:0] pred_i,
    input  logic        [5:0]  idx_i,
    output logic signed [11:0] pred_o,
    output logic        [5:0]  idx_o
);

    logic        [10:0] step;
    logic        [14:0] prod;
    logic        [11:0] delta;
    logic signed [13:0] sum;
    logic signed [4:0]  adj;
    logic signed [6:0]  idx_sum;

    always_comb begin
        step  = step_of(idx_i);
        // (2m+1) is just {m,1}; the product tops out at 1552*15 which fits 15 bits
        prod  = 15'(step) * 15'({code_i[2:0], 1'b1});
        delta = 12'(prod >> 3);
        if (code_i[3]) begin
            sum = $signed({{2{pred_i[11]}}, pred_i}) - $signed({2'b00, delta});
        end else begin
            sum = $signed({{2{pred_i[11]}}, pred_i}) + $signed({2'b00, delta});
        end

        if (sum > 14'sd2047) begin
            pred_o = PRED_MAX;
        end else if (sum < -14'sd2048) begin
            pred_o = PRED_MIN;
        end else begin
            pred_o = sum[11:0];
        end

        adj     = IDX_DELTA[code_i[2:0]];
        idx_sum = $signed({1'b0, idx_i}) + $signed({{2{adj[4]}}, adj});
        if (idx_sum < 7'sd0) begin
            idx_o = '0;
        end else if (idx_sum > $signed(7'(IDX_MAX))) begin
            idx_o = 6'(IDX_MAX);
        end else begin
            idx_o = idx_sum[5:0];
        end
    end

endmodule

// File: rtl/jt6295_encoder.sv
// Streaming MSM6295-compatible 4-bit ADPCM encoder: 12-bit PCM in, packed code bytes out.
// IDLE: wait for sample/start/flush | DIFF: sign,|d| | Q2/Q1/Q0: one code bit each | UPD: predictor update + pack
module jt6295_encoder
    import jt6295_pkg::*;
#(
    parameter int ADDR_W = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cen,
    input  logic               start,
    input  logic               flush,
    input  logic signed [11:0] pcm_in,
    input  logic               pcm_valid,
    output logic               pcm_ready,
    output logic [7:0]         enc_data,
    output logic               enc_valid,
    input  logic               enc_ready,
    output logic [ADDR_W-1:0]  byte_cnt,
    output logic               busy
);

    enc_state_e         state_q, state_d;
    logic signed [11:0] pcm_q;
    logic signed [11:0] pred_q;
    logic        [5:0]  idx_q;
    logic               sign_q;
    logic        [12:0] r_q;
    logic        [2:0]  mag_q;
    logic               phase_hi_q;
    logic        [3:0]  held_q;
    logic        [7:0]  data_q;
    logic               valid_q;
    logic [ADDR_W-1:0]  cnt_q;
    logic               flush_pend_q;

    logic               can_cmd, start_ok, accept, flush_go, xfer;
    logic        [12:0] diff, step13;
    logic        [10:0] step;
    logic        [3:0]  upd_code;
    logic signed [11:0] upd_pred;
    logic        [5:0]  upd_idx;

    always_comb begin
        can_cmd   = (state_q == ST_IDLE) && !valid_q;
        start_ok  = can_cmd && start;
        pcm_ready = can_cmd && !start && !rst;
        accept    = pcm_valid && pcm_ready && cen;
        flush_go  = can_cmd && !start && (flush || flush_pend_q) && !phase_hi_q && cen;
        xfer      = valid_q && enc_ready && cen;
        // 13-bit wrap-around subtraction is exact for the 12-bit operand range
        diff      = {pcm_q[11], pcm_q} - {pred_q[11], pred_q};
        step      = step_of(idx_q);
        step13    = {2'b00, step};
        upd_code  = (state_q == ST_UPD) ? {sign_q, mag_q} : 4'h0;
    end

    jt6295_enc_update u_update (
        .code_i (upd_code),
        .pred_i (pred_q),
        .idx_i  (idx_q),
        .pred_o (upd_pred),
        .idx_o  (upd_idx)
    );

    always_comb begin
        state_d = state_q;
        if (cen) begin
            case (state_q)
                ST_IDLE: if (accept) state_d = ST_DIFF;
                ST_DIFF: state_d = ST_Q2;
                ST_Q2:   state_d = ST_Q1;
                ST_Q1:   state_d = ST_Q0;
                ST_Q0:   state_d = ST_UPD;
                ST_UPD:  state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pcm_q        <= '0;
            pred_q       <= '0;
            idx_q        <= '0;
            sign_q       <= 1'b0;
            r_q          <= '0;
            mag_q        <= '0;
            phase_hi_q   <= 1'b1;
            held_q       <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
        end else if (cen) begin
            if (accept) pcm_q <= pcm_in;

            case (state_q)
                ST_DIFF: begin
                    sign_q <= diff[12];
                    r_q    <= diff[12] ? (~diff + 13'd1) : diff;
                end
                ST_Q2: begin
                    if (r_q >= step13) begin
                        mag_q[2] <= 1'b1;
                        r_q      <= r_q - step13;
                    end else begin
                        mag_q[2] <= 1'b0;
                    end
                end
                ST_Q1: begin
                    if (r_q >= {3'b000, step[10:1]}) begin
                        mag_q[1] <= 1'b1;
                        r_q      <= r_q - {3'b000, step[10:1]};
                    end else begin
                        mag_q[1] <= 1'b0;
                    end
                end
                ST_Q0: mag_q[0] <= (r_q >= {4'b0000, step[10:2]});
                ST_UPD: begin
                    pred_q <= upd_pred;
                    idx_q  <= upd_idx;
                    if (phase_hi_q) begin
                        held_q     <= {sign_q, mag_q};
                        phase_hi_q <= 1'b0;
                    end else begin
                        data_q     <= {held_q, sign_q, mag_q};
                        valid_q    <= 1'b1;
                        phase_hi_q <= 1'b1;
                    end
                end
                default: ;
            endcase

            // the zero pad nibble advances pred/idx just as the decoder will when it plays it
            if (flush_go) begin
                pred_q     <= upd_pred;
                idx_q      <= upd_idx;
                data_q     <= {held_q, 4'h0};
                valid_q    <= 1'b1;
                phase_hi_q <= 1'b1;
            end

            if (start_ok) begin
                pred_q     <= '0;
                idx_q      <= '0;
                phase_hi_q <= 1'b1;
                cnt_q      <= '0;
            end

            if (can_cmd) begin
                flush_pend_q <= 1'b0;
            end else if (flush) begin
                flush_pend_q <= 1'b1;
            end

            if (xfer) begin
                valid_q <= 1'b0;
                cnt_q   <= cnt_q + ADDR_W'(1);
            end
        end
    end

    assign enc_data  = data_q;
    assign enc_valid = valid_q;
    assign byte_cnt  = cnt_q;
    assign busy      = (state_q != ST_IDLE) || !phase_hi_q;

endmodule

// File: tb/tb_jt6295_encoder.sv
// Self-checking bench for jt6295_encoder against an arithmetic ADPCM reference model.
module tb_jt6295_encoder;

    logic        clk = 1'b0;
    logic        rst, cen, start, flush, pcm_valid, enc_ready;
    logic [11:0] pcm_in;
    logic        pcm_ready, enc_valid, busy;
    logic [7:0]  enc_data;
    logic [17:0] byte_cnt;

    jt6295_encoder #(.ADDR_W(18)) dut (
        .clk       (clk),
        .rst       (rst),
        .cen       (cen),
        .start     (start),
        .flush     (flush),
        .pcm_in    (pcm_in),
        .pcm_valid (pcm_valid),
        .pcm_ready (pcm_ready),
        .enc_data  (enc_data),
        .enc_valid (enc_valid),
        .enc_ready (enc_ready),
        .byte_cnt  (byte_cnt),
        .busy      (busy)
    );

    initial forever #5 clk = ~clk;

    int cen_mode = 0;
    int cen_ph   = 0;
    initial begin
        cen = 1'b1;
        forever begin
            @(negedge clk);
            cen_ph++;
            cen = (cen_mode == 0) || (cen_ph % 4 == 0);
        end
    end

    int step_tab [49] = '{16, 17, 19, 21, 23, 25, 28, 31, 34, 37, 41, 45, 50, 55, 60, 66,
                          73, 80, 88, 97, 107, 118, 130, 143, 157, 173, 190, 209, 230, 253,
                          279, 307, 337, 371, 408, 449, 494, 544, 598, 658, 724, 796, 876,
                          963, 1060, 1166, 1282, 1411, 1552};
    int idx_adj [8] = '{-1, -1, -1, -1, 2, 4, 6, 8};

    int         m_pred, m_idx, m_hi, m_held, m_cnt;
    logic [7:0] exp_q [$];
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // decoder view of one nibble
    function automatic void model_nib(input int code);
        int mag, delta;
        mag   = code % 8;
        delta = (step_tab[m_idx] * (2 * mag + 1)) / 8;
        m_pred = (code >= 8) ? m_pred - delta : m_pred + delta;
        if (m_pred > 2047)  m_pred = 2047;
        if (m_pred < -2048) m_pred = -2048;
        m_idx = m_idx + idx_adj[mag];
        if (m_idx < 0)  m_idx = 0;
        if (m_idx > 48) m_idx = 48;
    endfunction

    function automatic void model_sample(input int s);
        int d, r, st, code;
        d  = s - m_pred;
        r  = (d < 0) ? -d : d;
        st = step_tab[m_idx];
        code = 0;
        if (r >= st)     begin code += 4; r -= st;     end
        if (r >= st / 2) begin code += 2; r -= st / 2; end
        if (r >= st / 4) code += 1;
        if (d < 0) code += 8;
        model_nib(code);
        if (m_hi != 0) begin
            m_held = code;
            m_hi   = 0;
        end else begin
            exp_q.push_back(8'(m_held * 16 + code));
            m_hi = 1;
        end
    endfunction

    function automatic void model_reset();
        m_pred = 0; m_idx = 0; m_hi = 1; m_held = 0;
    endfunction

    // byte monitor: judged just before the edge that transfers it
    logic [7:0] mon_exp;
    initial forever begin
        @(negedge clk); #1;
        if (!rst && cen && enc_valid && enc_ready) begin
            check("byte_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                mon_exp = exp_q.pop_front();
                check("byte_data", 32'(enc_data), 32'(mon_exp));
            end
            m_cnt++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic tick_cen();
        logic en;
        do begin
            @(negedge clk); #1;
            en = cen;
            @(posedge clk); #1;
        end while (!en);
    endtask

    task automatic accept_only(input int s);
        int   n;
        logic acc;
        pcm_in = 12'(s); pcm_valid = 1'b1; n = 0;
        do begin
            @(negedge clk); #1;
            acc = pcm_ready && cen;
            @(posedge clk); #1;
            n++;
        end while (!acc && n < 400);
        pcm_valid = 1'b0;
        check("accept_in_time", 32'(acc), 32'd1);
        if (acc) model_sample(s);
    endtask

    task automatic push(input int s);
        accept_only(s);
        repeat (5) tick_cen();
        check("pred", 32'(dut.pred_q), 32'(m_pred));
        check("idx", 32'(dut.idx_q), 32'(m_idx));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(pcm_ready && !enc_valid) && n < 400) begin
            tick();
            n++;
        end
        check("idle_in_time", 32'(pcm_ready && !enc_valid), 32'd1);
    endtask

    task automatic do_start();
        wait_idle();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        start = 1'b1;
        tick_cen();
        start = 1'b0;
        model_reset();
        m_cnt = 0;
        check("start_cnt", 32'(byte_cnt), 32'd0);
    endtask

    int saw_max, saw_min, saw_i48;

    initial begin
        rst = 1'b1; start = 1'b0; flush = 1'b0; pcm_valid = 1'b0; pcm_in = '0; enc_ready = 1'b1;
        model_reset(); m_cnt = 0;
        repeat (3) tick();
        check("rst_pcm_ready", 32'(pcm_ready), 32'd0);
        check("rst_enc_valid", 32'(enc_valid), 32'd0);
        check("rst_enc_data", 32'(enc_data), 32'd0);
        check("rst_byte_cnt", 32'(byte_cnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", 32'(pcm_ready), 32'd1);

        // 100,100 -> 0x77
        do_start();
        push(100);
        check("p100_pred", 32'(dut.pred_q), 32'd30);
        check("p100_idx", 32'(dut.idx_q), 32'd8);
        push(100);
        check("p77_valid", 32'(enc_valid), 32'd1);
        check("p77_data", 32'(enc_data), 32'h77);
        check("p100b_pred", 32'(dut.pred_q), 32'd93);
        check("p100b_idx", 32'(dut.idx_q), 32'd16);
        wait_idle();
        check("p77_cnt", 32'(byte_cnt), 32'd1);

        // 0,0 -> 0x08
        do_start();
        push(0);
        check("z_pred", 32'(dut.pred_q), 32'd2);
        push(0);
        check("z_data", 32'(enc_data), 32'h08);
        check("z_pred2", 32'(dut.pred_q), 32'd0);
        check("z_idx", 32'(dut.idx_q), 32'd0);

        // random samples
        do_start();
        for (int i = 0; i < 40; i++) push(int'($urandom_range(4095)) - 2048);
        wait_idle();
        check("rand_cnt", 32'(byte_cnt), 32'(m_cnt));

        // start beats a simultaneous sample
        wait_idle();
        pcm_in = 12'd5; pcm_valid = 1'b1; start = 1'b1;
        @(negedge clk); #1;
        check("start_blocks_ready", 32'(pcm_ready), 32'd0);
        @(posedge clk); #1;
        start = 1'b0; pcm_valid = 1'b0;
        model_reset(); m_cnt = 0;
        check("start_no_accept", 32'(busy), 32'd0);
        check("start_clr_cnt", 32'(byte_cnt), 32'd0);

        // full scale saturation
        saw_max = 0; saw_min = 0; saw_i48 = 0;
        for (int i = 0; i < 200; i++) begin
            push(2047);
            if (dut.pred_q == 12'sh7FF) saw_max = 1;
            if (dut.idx_q == 6'd48) saw_i48 = 1;
        end
        check("fs_pred_max", 32'(dut.pred_q), 32'd2047);
        for (int i = 0; i < 200; i++) begin
            push(-2048);
            if (dut.pred_q == 12'sh800) saw_min = 1;
            if (dut.idx_q == 6'd48) saw_i48 = 1;
        end
        check("fs_saw_max", 32'(saw_max), 32'd1);
        check("fs_saw_min", 32'(saw_min), 32'd1);
        check("fs_saw_idx48", 32'(saw_i48), 32'd1);

        // backpressure
        do_start();
        enc_ready = 1'b0;
        push(300);
        push(-300);
        pcm_in = 12'd777; pcm_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("bp_ready_low", 32'(pcm_ready), 32'd0);
            check("bp_valid", 32'(enc_valid), 32'd1);
            check("bp_data", 32'(enc_data), 32'(exp_q[0]));
        end
        enc_ready = 1'b1;
        tick();
        check("bp_xfer_valid", 32'(enc_valid), 32'd0);
        check("bp_ready_next", 32'(pcm_ready), 32'd1);
        tick();
        pcm_valid = 1'b0;
        model_sample(777);
        repeat (5) tick_cen();
        check("bp_pred", 32'(dut.pred_q), 32'(m_pred));
        check("bp_cnt", 32'(byte_cnt), 32'd1);

        // flush
        do_start();
        push(100);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        exp_q.push_back(8'(m_held * 16));
        model_nib(0);
        m_hi = 1;
        check("fl_valid", 32'(enc_valid), 32'd1);
        check("fl_data", 32'(enc_data), 32'h70);
        check("fl_pred", 32'(dut.pred_q), 32'd34);
        check("fl_pred_model", 32'(dut.pred_q), 32'(m_pred));
        tick();
        check("fl_cnt", 32'(byte_cnt), 32'd1);
        check("fl_busy", 32'(busy), 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl2_valid", 32'(enc_valid), 32'd0);
        repeat (3) tick();
        check("fl2_cnt", 32'(byte_cnt), 32'd1);

        // reset while the second nibble is in Q1
        do_start();
        push(200);
        accept_only(100);
        repeat (2) tick_cen();
        rst = 1'b1;
        #1;
        check("mid_rst_ready", 32'(pcm_ready), 32'd0);
        tick();
        model_reset(); m_cnt = 0; exp_q.delete();
        check("mid_rst_valid", 32'(enc_valid), 32'd0);
        check("mid_rst_cnt", 32'(byte_cnt), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_pred", 32'(dut.pred_q), 32'd0);
        rst = 1'b0;

        // cen every 4th cycle: latency counted in cen cycles
        cen_mode = 1;
        accept_only(100);
        repeat (4) tick_cen();
        check("cen_lat_early", 32'(dut.pred_q), 32'd0);
        tick_cen();
        check("cen_lat_pred", 32'(dut.pred_q), 32'd30);
        check("cen_lat_code", 32'(dut.held_q), 32'h7);
        check("cen_lat_idx", 32'(dut.idx_q), 32'(m_idx));
        cen_mode = 0;
        repeat (4) tick();
        check("final_cnt", 32'(byte_cnt), 32'(m_cnt));
        check("final_queue", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
